// File: rtl/proj_pkg.sv
// Shared constants and types for the MinHash hasher -> sorter path.
package proj_pkg;

    localparam int HASHER_SORTER_SIGNATURE = 32;
    localparam int SORTER_INDICE_LEN       = 8;
    localparam int SORTER_TOPK_DEPTH       = 8;

    typedef struct packed {
        logic [HASHER_SORTER_SIGNATURE-1:0] sig;
        logic [SORTER_INDICE_LEN-1:0]       idx;
    } signature_index_pack;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } sorter_state_e;

endpackage

// File: rtl/minhash_sorter_slot.sv
// One entry of the sorted top-k array: holds {sig, idx}, compares against the
// incoming signature and selects hold / load-new / shift-up / shift-down.
module minhash_sorter_slot #(
    parameter int SIG_W = 32,
    parameter int IDX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ins_en,
    input  logic                   shift_dn,
    input  logic [SIG_W-1:0]       in_sig,
    input  logic [IDX_W-1:0]       in_idx,
    input  logic                   below_ge,
    input  logic                   below_valid,
    input  logic [SIG_W+IDX_W-1:0] below_data,
    input  logic                   above_valid,
    input  logic [SIG_W+IDX_W-1:0] above_data,
    output logic                   valid,
    output logic [SIG_W+IDX_W-1:0] data,
`ifdef MINHASH_SORTER_DEDUP_EN
    output logic                   eq,
`endif
    output logic                   ge
);

    logic                   valid_q, valid_d;
    logic [SIG_W+IDX_W-1:0] data_q, data_d;
    logic [SIG_W-1:0]       sig_q;

    assign sig_q = data_q[SIG_W+IDX_W-1 -: SIG_W];

    // ge marks "new beat lands here or below": empty, or strictly greater, so equal sigs keep arrival order.
    assign ge    = !valid_q || (sig_q > in_sig);
`ifdef MINHASH_SORTER_DEDUP_EN
    assign eq    = valid_q && (sig_q == in_sig);
`endif
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (shift_dn) begin
            valid_d = above_valid;
            data_d  = above_data;
        end else if (ins_en && ge) begin
            if (below_ge) begin
                valid_d = below_valid;
                data_d  = below_data;
            end else begin
                valid_d = 1'b1;
                data_d  = {in_sig, in_idx};
            end
        end
    end

    // NOTE: data is reset too (not just valid) because slot 0 drives out_sig/out_idx, which must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all flop state to avoid simulation races between blocks.
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/minhash_topk_sorter.sv
// Keeps the DEPTH smallest signatures of a frame in ascending order and drains them.
// Optional macro MINHASH_SORTER_DEDUP_EN drops beats whose signature is already held.
module minhash_topk_sorter
    import proj_pkg::*;
#(
    parameter int SIG_W = HASHER_SORTER_SIGNATURE,
    parameter int IDX_W = SORTER_INDICE_LEN,
    parameter int DEPTH = SORTER_TOPK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIG_W-1:0]           in_sig,
    input  logic [IDX_W-1:0]           in_idx,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIG_W-1:0]           out_sig,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] out_count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Same bit layout as signature_index_pack at default widths.
    typedef struct packed {
        logic [SIG_W-1:0] sig;
        logic [IDX_W-1:0] idx;
    } slot_t;

    sorter_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic  slot_valid [DEPTH];
    slot_t slot_data  [DEPTH];
    logic  slot_ge    [DEPTH];

    logic in_fire, out_fire, ins_en, dup;

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef MINHASH_SORTER_DEDUP_EN
    logic slot_eq [DEPTH];

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) dup = dup | slot_eq[i];
    end
`else
    assign dup = 1'b0;
`endif

    // The top slot's ge covers both cases: empty (not full) or holding a larger sig (evict).
    assign ins_en = in_fire && slot_ge[DEPTH-1] && !dup;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic                   below_ge, below_valid, above_valid;
        logic [SIG_W+IDX_W-1:0] below_data, above_data;

        if (i == 0) begin : g_bottom
            assign below_ge    = 1'b0;
            assign below_valid = 1'b0;
            assign below_data  = '0;
        end else begin : g_mid_lo
            assign below_ge    = slot_ge[i-1];
            assign below_valid = slot_valid[i-1];
            assign below_data  = slot_data[i-1];
        end

        if (i == DEPTH-1) begin : g_top
            assign above_valid = 1'b0;
            assign above_data  = '0;
        end else begin : g_mid_hi
            assign above_valid = slot_valid[i+1];
            assign above_data  = slot_data[i+1];
        end

        minhash_sorter_slot #(
            .SIG_W (SIG_W),
            .IDX_W (IDX_W)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .ins_en      (ins_en),
            .shift_dn    (out_fire),
            .in_sig      (in_sig),
            .in_idx      (in_idx),
            .below_ge    (below_ge),
            .below_valid (below_valid),
            .below_data  (below_data),
            .above_valid (above_valid),
            .above_data  (above_data),
            .valid       (slot_valid[i]),
            .data        (slot_data[i]),
`ifdef MINHASH_SORTER_DEDUP_EN
            .eq          (slot_eq[i]),
`endif
            .ge          (slot_ge[i])
        );
    end

    assign out_sig   = slot_data[0].sig;
    assign out_idx   = slot_data[0].idx;
    assign out_last  = out_valid && (count_q == ONE_C);
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (ins_en && (count_q != DEPTH_C)) count_d = count_q + ONE_C;
        if (in_fire && in_last) state_d = DRAIN;
        if (out_fire) begin
            count_d = count_q - ONE_C;
            if (count_q == ONE_C) state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_minhash_topk_sorter.sv
// Directed self-checking bench for minhash_topk_sorter at DEPTH=4.
module tb_minhash_topk_sorter;

    localparam int SIG_W = 32;
    localparam int IDX_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_last;
    logic [SIG_W-1:0] in_sig;
    logic [IDX_W-1:0] in_idx;
    logic             out_valid, out_ready, out_last;
    logic [SIG_W-1:0] out_sig;
    logic [IDX_W-1:0] out_idx;
    logic [CNT_W-1:0] out_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    minhash_topk_sorter #(
        .SIG_W (SIG_W),
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sig    (in_sig),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_count (out_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("comparison %s differs", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SIG_W-1:0] s, input logic [IDX_W-1:0] ix, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_sig   = s;
        in_idx   = ix;
        in_last  = l;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("send_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [SIG_W-1:0] s, input logic [IDX_W-1:0] ix,
                        input logic l, input int cnt);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sig"},   out_sig,   s);
        check({tag, "_idx"},   out_idx,   ix);
        check({tag, "_last"},  out_last,  l);
        check({tag, "_count"}, out_count, cnt);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sig    = '0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_sig",   out_sig,   0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_last",  out_last,  0);
        step();
        rst_n = 1'b1;
        step();
        check("rel_in_ready",  in_ready,  1);
        check("rel_out_valid", out_valid, 0);

        // Sort with eviction: 50 is discarded once full
        send(40, 0, 0);
        send(10, 1, 0);
        send(30, 2, 0);
        send(20, 3, 0);
        send(50, 4, 1);
        check("f1_valid_next", out_valid, 1);
        check("f1_in_ready",   in_ready,  0);
        recv("f1_o0", 10, 1, 0, 4);
        recv("f1_o1", 20, 3, 0, 3);
        recv("f1_o2", 30, 2, 0, 2);
        recv("f1_o3", 40, 0, 1, 1);
        check("f1_done_valid", out_valid, 0);
        check("f1_done_ready", in_ready,  1);
        check("f1_done_count", out_count, 0);

        // Short frame
        send(7, 0, 0);
        send(3, 1, 1);
        recv("f2_o0", 3, 1, 0, 2);
        recv("f2_o1", 7, 0, 1, 1);

        // Duplicate signatures
        send(5, 1, 0);
        send(5, 2, 0);
        send(1, 3, 1);
`ifdef MINHASH_SORTER_DEDUP_EN
        recv("f3_o0", 1, 3, 0, 2);
        recv("f3_o1", 5, 1, 1, 1);
`else
        recv("f3_o0", 1, 3, 0, 3);
        recv("f3_o1", 5, 1, 0, 2);
        recv("f3_o2", 5, 2, 1, 1);
`endif

        // Backpressure during drain with a stray input offered
        send(8, 0, 0);
        send(6, 1, 1);
        in_valid = 1'b1;
        in_sig   = 1;
        in_idx   = 9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid",    out_valid, 1);
            check("bp_sig",      out_sig,   6);
            check("bp_idx",      out_idx,   1);
            check("bp_in_ready", in_ready,  0);
            check("bp_count",    out_count, 2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        recv("bp_o0", 6, 1, 0, 2);
        recv("bp_o1", 8, 0, 1, 1);
        check("bp_done_valid", out_valid, 0);
        check("bp_done_count", out_count, 0);

        // Reset mid-frame discards the frame
        send(11, 0, 0);
        send(12, 1, 0);
        send(13, 2, 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", out_count, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", out_valid, 0);
        end
        send(9, 5, 1);
        recv("r_o0", 9, 5, 1, 1);

        // Back-to-back frames with in_valid held high
        in_valid = 1'b1;
        in_sig   = 100;
        in_idx   = 0;
        in_last  = 1'b0;
        step();
        in_sig  = 50;
        in_idx  = 1;
        in_last = 1'b1;
        step();
        check("b2b_drain_valid", out_valid, 1);
        check("b2b_drain_ready", in_ready,  0);
        check("b2b_o0_sig",      out_sig,   50);
        in_sig    = 70;
        in_idx    = 2;
        in_last   = 1'b1;
        out_ready = 1'b1;
        step();
        check("b2b_o1_ready", in_ready, 0);
        check("b2b_o1_sig",   out_sig,  100);
        check("b2b_o1_last",  out_last, 1);
        step();
        check("b2b_back_ready", in_ready,  1);
        check("b2b_back_valid", out_valid, 0);
        check("b2b_back_count", out_count, 0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("b2b_f2_valid", out_valid, 1);
        check("b2b_f2_sig",   out_sig,   70);
        check("b2b_f2_idx",   out_idx,   2);
        check("b2b_f2_last",  out_last,  1);
        check("b2b_f2_count", out_count, 1);
        step();
        out_ready = 1'b0;
        check("b2b_end_valid", out_valid, 0);
        check("b2b_end_count", out_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/minhash_topk_sorter.md
MINHASH_TOPK_SORTER -- requirements
Module: minhash_topk_sorter

Interface
REQ-001 SHALL have parameter SIG_W, default HASHER_SORTER_SIGNATURE (32), signature width in bits.
REQ-002 SHALL have parameter IDX_W, default SORTER_INDICE_LEN (8), index width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, number of minimum signatures retained per frame, legal range 2..64.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, input beat valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts input beat.
REQ-008 SHALL have port in_sig, input, SIG_W, hashed k-mer signature.
REQ-009 SHALL have port in_idx, input, IDX_W, k-mer position index.
REQ-010 SHALL have port in_last, input, 1, final beat of frame.
REQ-011 SHALL have port out_valid, output, 1, output entry valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts entry.
REQ-013 SHALL have port out_sig, output, SIG_W, retained signature.
REQ-014 SHALL have port out_idx, output, IDX_W, index paired with out_sig.
REQ-015 SHALL have port out_last, output, 1, final retained entry of frame.
REQ-016 SHALL have port out_count, output, $clog2(DEPTH+1), number of entries held.

Function
REQ-017 A beat SHALL transfer on the cycle in_valid && in_ready is high; output SHALL transfer on out_valid && out_ready.
REQ-018 FSM SHALL have two states: COLLECT (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-019 In COLLECT, each accepted beat SHALL be inserted into an ascending-sorted slot array in the same clock edge (one beat per cycle, no stall).
REQ-020 Beat SHALL be inserted when out_count < DEPTH, or when in_sig < sig of slot DEPTH-1; otherwise discarded.
REQ-021 Insertion position SHALL be after all slots with sig <= in_sig (stable ordering; equal signatures keep arrival order); slots at and above the position shift up one, slot DEPTH-1 is evicted when full.
REQ-022 out_count SHALL increment on insertion when < DEPTH and saturate at DEPTH.
REQ-023 Comparison SHALL be unsigned on SIG_W bits; in_idx SHALL not take part in ordering.
REQ-024 Accepting a beat with in_last=1 SHALL process that beat then enter DRAIN on the next cycle (out_valid high one cycle after the last input handshake).
REQ-025 In DRAIN, out_sig/out_idx SHALL present slot 0; each output handshake shifts the array down one and decrements out_count.
REQ-026 out_last SHALL be high when out_valid and out_count == 1.
REQ-027 After the out_last handshake, FSM SHALL return to COLLECT with out_count=0; in_ready high the following cycle.
REQ-028 Outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-029 rst_n low SHALL immediately force COLLECT, out_count=0, all slot valid flags cleared, out_valid=0, out_last=0, out_sig=0, out_idx=0; in_ready SHALL be 1 after release.
REQ-030 Reset asserted mid-frame or mid-drain SHALL discard the frame with no output.

Configuration
REQ-031 Macro MINHASH_SORTER_DEDUP_EN defined: a beat whose in_sig equals any held sig SHALL be discarded (first occurrence kept, out_count unchanged).
REQ-032 Macro undefined: duplicates SHALL be inserted per REQ-021.

Structure
REQ-033 signature_index_pack, HASHER_SORTER_SIGNATURE, SORTER_INDICE_LEN and new constant SORTER_TOPK_DEPTH (8) SHALL reside in proj_pkg; slots SHALL be arrays of signature_index_pack when widths are default.
REQ-034 One sub-module, minhash_sorter_slot, SHALL implement a single slot (compare, hold, shift-up/shift-down mux) and be generated DEPTH times.

Verification
REQ-035 DEPTH=4, sigs 40,10,30,20,50(last) -> outputs 10,20,30,40, out_last on 40, 50 discarded.
REQ-036 DEPTH=4, sigs 7,3(last) -> outputs 3,7, out_count 2 then 1, out_last on 7.
REQ-037 Sigs 5(idx1),5(idx2),1(last): without DEDUP_EN -> (1),(5,1),(5,2); with DEDUP_EN -> (1),(5,1).
REQ-038 out_ready held low 5 cycles during DRAIN -> out_sig/out_idx stable, in_ready 0, no input accepted.
REQ-039 rst_n pulsed after 3 beats of a frame -> out_valid never asserts, next frame 9(last) -> single output 9 with out_last.
REQ-040 Back-to-back frames, in_valid constant high -> in_ready deasserts during DRAIN, first beat of frame 2 accepted the cycle after frame 1 out_last handshake.
